twos_complement_thermometer_serializer: RTL and testbench
=========================================================

# twos_complement_thermometer_serializer

Converts a parallel two's-complement word back into a serial thermometer stream with a sign flag. It is the inverse of the serial thermometer/binary-to-two's-complement conversion path in the partial product adder. Each accepted word is decoded to sign and magnitude. The block then emits one frame of thermometer bits, 1 s first and then 0 s, on a valid/ready serial port for downstream serial-thermometer consumers.

## Interface
- WIDTH, 5, input word width in bits; maximum magnitude M = 2^(WIDTH-1), which is also the full frame length.
- clk  input  1  clock; all logic on the rising edge.
- rst  input  1  reset, asynchronous and active-high.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  block can accept a word.
- in_data  input  WIDTH  two's-complement value to serialize.
- ser_valid  output  1  ser_bit, ser_sign and ser_last are valid.
- ser_ready  input  1  downstream accepts the current beat.
- ser_bit  output  1  current thermometer bit.
- ser_sign  output  1  sign of the current frame (1 = negative); constant for the whole frame.
- ser_last  output  1  current beat is the last beat of the frame.

## Operation
- States:
  - IDLE (in_ready=1, ser_valid=0).
  - SHIFT (in_ready=0, ser_valid=1).
- Input transfer: in_valid && in_ready at a rising edge.
  - Registers sign = in_data[WIDTH-1].
  - Registers mag = sign ? (~in_data + 1) : in_data, as an unsigned WIDTH-bit value.
  - Clears beat counter cnt (WIDTH bits) to 0 and moves to SHIFT.
- Magnitude rules:
  - in_data = 0 gives sign=0, mag=0.
  - The most negative value (1 followed by zeros) gives mag = M. WIDTH bits hold it unsigned, so there is no overflow.
- Output in SHIFT:
  - ser_bit = (cnt < mag).
  - ser_sign = sign.
  - ser_last = (cnt == L-1), where L is the frame length (see Configuration).
- Output transfer: ser_valid && ser_ready.
  - Not last beat: cnt increments.
  - Last beat: go to IDLE.
- Stall: ser_ready=0 in SHIFT holds cnt and all ser_* outputs stable.
- in_valid is ignored outside IDLE. No input word is buffered or lost, because in_ready=0.
- Reset:
  - Asynchronous; clears state to IDLE, and cnt, mag and sign to 0.
  - Reset during SHIFT abandons the frame immediately.
  - No partial frame resumes after release.

## Timing
- Reset values: in_ready=1, ser_valid=0, ser_bit=0, ser_sign=0, ser_last=0.
- Latency: the first beat is presented the cycle after the input transfer (ser_valid rises on the edge that accepts the word).
- With ser_ready held at 1, a frame occupies exactly L consecutive cycles.
- in_ready returns to 1 the cycle after the last-beat transfer. Throughput is one word per L+1 cycles.
- in_ready is a function of state only. It never depends combinationally on in_valid.
- All ser_* outputs come from registered state and cnt/mag compares. They have no combinational path from ser_ready.
- Counter wrap: cnt never exceeds L-1, so it never wraps.

## Configuration
- Macro: THERM_EARLY_LAST_EN.
- Undefined (default): fixed frame length L = M beats. Bits are mag ones, then M-mag zeros.
- Defined: early-terminated frame, L = max(mag, 1).
  - Frame contains only the ones, with ser_last on the last one.
  - mag=0 emits a single beat with ser_bit=0, ser_last=1.
  - Throughput becomes L+1 cycles per word.

## Test plan
- WIDTH=5, ser_ready=1, in_data=5'b00011 (+3) -> 16 beats.
  - ser_bit = 1,1,1 then 13 zeros; ser_sign=0; ser_last only on beat 16.
  - in_ready=1 one cycle after beat 16.
  - With THERM_EARLY_LAST_EN: 3 beats of 1, ser_last on beat 3.
- in_data=5'b11101 (-3) -> sign=1 on all 16 beats, first 3 bits 1, rest 0.
- in_data=5'b10000 (-16) -> 16 beats all 1, ser_sign=1.
  - in_data=5'b01111 (+15) -> 15 ones then a single 0.
- in_data=5'b00000 -> 16 zero beats, ser_sign=0.
  - With THERM_EARLY_LAST_EN: one beat, ser_bit=0, ser_last=1.
- in_data=5'b00101 (+5) with ser_ready toggled pseudo-randomly.
  - Outputs hold stable while stalled.
  - Exactly 5 ones are transferred, then 11 zeros.
  - in_valid pulses during SHIFT are never accepted.
- Assert rst asynchronously (mid-cycle) after 6 transferred beats of +9.
  - ser_valid=0 and in_ready=1 immediately.
  - After release, in_data=5'b11110 (-2) yields a clean frame: 2 ones, sign=1.

Source files
------------

// File: rtl/twos_complement_thermometer_serializer.sv
// Two's-complement word to sign + serial thermometer frame (ones first, then zeros).
// Define THERM_EARLY_LAST_EN to end each frame on its last one (L = max(mag,1)) instead of after 2^(WIDTH-1) beats.
module twos_complement_thermometer_serializer #(
    parameter int WIDTH = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             ser_valid,
    input  logic             ser_ready,
    output logic             ser_bit,
    output logic             ser_sign,
    output logic             ser_last
);

    localparam logic [WIDTH-1:0] MAX_MAG = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t           state_q, state_d;
    logic             sign_q, sign_d;
    logic [WIDTH-1:0] mag_q, mag_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] last_d;
    logic             in_ready_q, ser_valid_q, ser_bit_q, ser_sign_q, ser_last_q;

    // The most negative input maps to MAX_MAG, which still fits unsigned in WIDTH bits.
    function automatic logic [WIDTH-1:0] abs_mag(input logic [WIDTH-1:0] v);
        return v[WIDTH-1] ? (~v + 1'b1) : v;
    endfunction

    always_comb begin
        state_d = state_q;
        sign_d  = sign_q;
        mag_d   = mag_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (in_valid && in_ready_q) begin
                    sign_d  = in_data[WIDTH-1];
                    mag_d   = abs_mag(in_data);
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (ser_valid_q && ser_ready) begin
                    if (ser_last_q) state_d = IDLE;
                    else            cnt_d   = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
`ifdef THERM_EARLY_LAST_EN
        last_d = (mag_d == '0) ? '0 : (mag_d - 1'b1);
`else
        last_d = MAX_MAG - 1'b1;
`endif
    end

    // Outputs are registered from next-state values, so nothing reaches ser_* from ser_ready combinationally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            sign_q      <= 1'b0;
            mag_q       <= '0;
            cnt_q       <= '0;
            in_ready_q  <= 1'b1;
            ser_valid_q <= 1'b0;
            ser_bit_q   <= 1'b0;
            ser_sign_q  <= 1'b0;
            ser_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            sign_q      <= sign_d;
            mag_q       <= mag_d;
            cnt_q       <= cnt_d;
            in_ready_q  <= (state_d == IDLE);
            ser_valid_q <= (state_d == SHIFT);
            ser_bit_q   <= (state_d == SHIFT) && (cnt_d < mag_d);
            ser_sign_q  <= (state_d == SHIFT) && sign_d;
            ser_last_q  <= (state_d == SHIFT) && (cnt_d == last_d);
        end
    end

    assign in_ready  = in_ready_q;
    assign ser_valid = ser_valid_q;
    assign ser_bit   = ser_bit_q;
    assign ser_sign  = ser_sign_q;
    assign ser_last  = ser_last_q;

endmodule

// File: tb/tb_twos_complement_thermometer_serializer.sv
// Directed bench for twos_complement_thermometer_serializer (WIDTH=5); follows THERM_EARLY_LAST_EN if defined.
module tb_twos_complement_thermometer_serializer;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [4:0] in_data;
    logic       ser_valid;
    logic       ser_ready;
    logic       ser_bit;
    logic       ser_sign;
    logic       ser_last;

    int checks = 0;
    int errors = 0;

    twos_complement_thermometer_serializer #(.WIDTH(5)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .ser_valid (ser_valid),
        .ser_ready (ser_ready),
        .ser_bit   (ser_bit),
        .ser_sign  (ser_sign),
        .ser_last  (ser_last)
    );

    always #5 clk = ~clk;

    function automatic int exp_len(input int mag);
`ifdef THERM_EARLY_LAST_EN
        return (mag == 0) ? 1 : mag;
`else
        return 16;
`endif
    endfunction

    task automatic check_idle(input string name);
        checks++;
        if ({ser_valid, in_ready, ser_bit, ser_sign, ser_last} !== 5'b01000) begin
            errors++;
            $display("FAIL %s: valid/ready/bit/sign/last = %b, expected 01000", name,
                     {ser_valid, in_ready, ser_bit, ser_sign, ser_last});
        end
    endtask

    // Sends one word and checks every beat of the resulting frame against a reference magnitude.
    task automatic run_frame(input logic [4:0] data, input bit stall, input string name);
        logic exp_sign;
        int   mag, len, b, cyc, ones;
        logic rdy, prev_stalled;
        logic [2:0] prev_out;
        exp_sign     = data[4];
        mag          = exp_sign ? (32 - int'(data)) : int'(data);
        len          = exp_len(mag);
        b            = 0;
        cyc          = 0;
        ones         = 0;
        prev_stalled = 1'b0;
        prev_out     = 3'b000;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s_accept: in_ready=%b, expected 1", name, in_ready);
        end
        in_valid  = 1'b1;
        in_data   = data;
        ser_ready = 1'b0;
        while (b < len && cyc < 400) begin
            @(negedge clk);
            cyc++;
            in_valid = stall ? 1'($urandom_range(0, 1)) : 1'b0;
            in_data  = stall ? 5'b01111 : data;
            checks++;
            if (ser_valid !== 1'b1 || in_ready !== 1'b0) begin
                errors++;
                $display("FAIL %s_hs beat %0d: ser_valid=%b in_ready=%b, expected 1 0", name, b, ser_valid, in_ready);
            end
            checks++;
            if ({ser_bit, ser_sign, ser_last} !== {1'(b < mag), exp_sign, 1'(b == len - 1)}) begin
                errors++;
                $display("FAIL %s_beat %0d: bit/sign/last=%b, expected %b", name, b,
                         {ser_bit, ser_sign, ser_last}, {1'(b < mag), exp_sign, 1'(b == len - 1)});
            end
            if (prev_stalled) begin
                checks++;
                if ({ser_bit, ser_sign, ser_last} !== prev_out) begin
                    errors++;
                    $display("FAIL %s_stall beat %0d: outputs=%b, held value %b", name, b,
                             {ser_bit, ser_sign, ser_last}, prev_out);
                end
            end
            rdy          = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            ser_ready    = rdy;
            prev_stalled = ~rdy;
            prev_out     = {ser_bit, ser_sign, ser_last};
            if (rdy) begin
                if (ser_bit === 1'b1) ones++;
                b++;
            end
        end
        checks++;
        if (b != len) begin
            errors++;
            $display("FAIL %s_timeout: beats transferred=%0d, expected %0d", name, b, len);
        end
        @(negedge clk);
        in_valid  = 1'b0;
        ser_ready = 1'b0;
        check_idle({name, "_done"});
        checks++;
        if (ones != mag) begin
            errors++;
            $display("FAIL %s_ones: transferred ones=%0d, expected %0d", name, ones, mag);
        end
        if (!stall) begin
            checks++;
            if (cyc != len) begin
                errors++;
                $display("FAIL %s_cycles: frame cycles=%0d, expected %0d", name, cyc, len);
            end
        end
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = 5'b00000;
        ser_ready = 1'b0;
        #12;
        check_idle("reset");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_idle("reset_release");
    endtask

    task automatic test_positive();
        run_frame(5'b00011, 1'b0, "plus3");
        run_frame(5'b01111, 1'b0, "plus15");
    endtask

    task automatic test_negative();
        run_frame(5'b11101, 1'b0, "minus3");
        run_frame(5'b10000, 1'b0, "minus16");
    endtask

    task automatic test_zero();
        run_frame(5'b00000, 1'b0, "zero");
    endtask

    task automatic test_stall();
        run_frame(5'b00101, 1'b1, "plus5_stall");
    endtask

    task automatic test_back_to_back();
        run_frame(5'b00001, 1'b0, "b2b_plus1");
        run_frame(5'b11111, 1'b0, "b2b_minus1");
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        in_valid  = 1'b1;
        in_data   = 5'b01001;
        ser_ready = 1'b1;
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            in_valid = 1'b0;
        end
        #2;
        rst = 1'b1;
        #1;
        check_idle("async_reset");
        @(negedge clk);
        #1;
        rst       = 1'b0;
        ser_ready = 1'b0;
        @(negedge clk);
        check_idle("async_reset_release");
        run_frame(5'b11110, 1'b0, "minus2_after_reset");
    endtask

    initial begin
        test_reset();
        test_positive();
        test_negative();
        test_zero();
        test_stall();
        test_back_to_back();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
